// File: rtl/tohost_reporter_pkg.sv
//------------------------------------------------------------------------------
// Module   : tohost_reporter_pkg
// Purpose  : Shared definitions for the tohost end-of-test reporter: default
//            tohost address, verdict and transmitter state encodings, message
//            lengths and the ASCII message byte generator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tohost_reporter_pkg;

  // Default word address decoded as tohost.
  localparam logic [31:0] c_TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  localparam logic [7:0] c_LF = 8'h0A;

  // Message lengths in bytes, and the index of the last byte of each.
  localparam int unsigned c_LEN_PASS    = 7;   // "passed" LF
  localparam int unsigned c_LEN_FAIL    = 16;  // "failed " + 8 hex digits + LF
  localparam int unsigned c_LEN_TIMEOUT = 8;   // "timeout" LF

  localparam logic [3:0] c_LAST_PASS    = 4'(c_LEN_PASS - 1);
  localparam logic [3:0] c_LAST_FAIL    = 4'(c_LEN_FAIL - 1);
  localparam logic [3:0] c_LAST_TIMEOUT = 4'(c_LEN_TIMEOUT - 1);

  // First byte index of the hex field inside the fail message.
  localparam logic [3:0] c_FAIL_HEX_START = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    VERDICT_PASS    = 2'd0,
    VERDICT_FAIL    = 2'd1,
    VERDICT_TIMEOUT = 2'd2
  } verdict_e;

  // Uppercase hex digit for a nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_ascii = 8'h30 + {4'h0, n};
    end else begin
      hex_ascii = 8'h37 + {4'h0, n};
    end
  endfunction

  // Index of the last message byte for a verdict.
  function automatic logic [3:0] msg_last(input verdict_e v);
    case (v)
      VERDICT_PASS:    msg_last = c_LAST_PASS;
      VERDICT_FAIL:    msg_last = c_LAST_FAIL;
      VERDICT_TIMEOUT: msg_last = c_LAST_TIMEOUT;
      default:         msg_last = c_LAST_PASS;
    endcase
  endfunction

  // Byte idx of the verdict line. The fail line prints {1'b0,tnum} as eight
  // hex digits, most significant nibble first.
  function automatic logic [7:0] msg_byte(input verdict_e v, input logic [3:0] idx,
                                          input logic [30:0] tnum);
    logic [31:0] word;
    logic [2:0]  digit;
    logic [31:0] shifted;
    word     = {1'b0, tnum};
    digit    = 3'(idx - c_FAIL_HEX_START);
    shifted  = word >> {3'd7 - digit, 2'b00};
    msg_byte = 8'h00;
    case (v)
      VERDICT_PASS: begin
        case (idx)
          4'd0:    msg_byte = "p";
          4'd1:    msg_byte = "a";
          4'd2:    msg_byte = "s";
          4'd3:    msg_byte = "s";
          4'd4:    msg_byte = "e";
          4'd5:    msg_byte = "d";
          default: msg_byte = c_LF;
        endcase
      end
      VERDICT_TIMEOUT: begin
        case (idx)
          4'd0:    msg_byte = "t";
          4'd1:    msg_byte = "i";
          4'd2:    msg_byte = "m";
          4'd3:    msg_byte = "e";
          4'd4:    msg_byte = "o";
          4'd5:    msg_byte = "u";
          4'd6:    msg_byte = "t";
          default: msg_byte = c_LF;
        endcase
      end
      VERDICT_FAIL: begin
        case (idx)
          4'd0:    msg_byte = "f";
          4'd1:    msg_byte = "a";
          4'd2:    msg_byte = "i";
          4'd3:    msg_byte = "l";
          4'd4:    msg_byte = "e";
          4'd5:    msg_byte = "d";
          4'd6:    msg_byte = " ";
          4'd15:   msg_byte = c_LF;
          default: msg_byte = hex_ascii(shifted[3:0]);
        endcase
      end
      default: msg_byte = 8'h00;
    endcase
  endfunction

endpackage : tohost_reporter_pkg

`default_nettype wire

// File: rtl/tohost_reporter_report_byte_tx.sv
//------------------------------------------------------------------------------
// Module   : report_byte_tx
// Purpose  : Streams the ASCII verdict line once, after the verdict latches,
//            over a byte valid/ready port.
// Ports    : clk, rst (async, active-low)
//            done, passed, timeout, test_num - latched verdict from the top
//            tx_valid, tx_data, tx_ready     - byte stream to the sink
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module report_byte_tx
  import tohost_reporter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic        passed,
  input  logic        timeout,
  input  logic [30:0] test_num,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  tx_state_e  r_state;
  tx_state_e  w_state_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  verdict_e   w_verdict;
  logic [3:0] w_last;

  // The verdict inputs are sticky once done rises, so the message selection
  // and therefore tx_data stay stable for the whole transfer, including while
  // the sink stalls.
  always_comb begin
    if (timeout) begin
      w_verdict = VERDICT_TIMEOUT;
    end else if (passed) begin
      w_verdict = VERDICT_PASS;
    end else begin
      w_verdict = VERDICT_FAIL;
    end
  end

  assign w_last = msg_last(w_verdict);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (done) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = 4'd0;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = msg_byte(w_verdict, r_idx, test_num);
        if (tx_ready) begin
          if (r_idx == w_last) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      ST_FIN: begin
        // Message already sent; stay silent until reset.
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : report_byte_tx

`default_nettype wire

// File: rtl/tohost_reporter.sv
//------------------------------------------------------------------------------
// Module   : tohost_reporter
// Purpose  : End-of-test reporter on the data-memory write port. Snoops word
//            stores to TOHOST_ADDR, latches the first terminal value as a
//            pass/fail verdict (or a timeout), drives sticky status flags and
//            streams an ASCII verdict line over a byte valid/ready port.
// Ports    : clk, rst (async, active-low)
//            wr_en, wr_addr, wr_data, wr_strb - snooped store port
//            done, passed, timeout, test_num  - sticky verdict flags
//            tx_valid, tx_data, tx_ready      - verdict byte stream
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tohost_reporter
  import tohost_reporter_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = c_TOHOST_ADDR_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        done,
  output logic        passed,
  output logic        timeout,
  output logic [30:0] test_num,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             r_done;
  logic             r_passed;
  logic             r_timeout;
  logic [30:0]      r_test_num;
  logic [CNT_W-1:0] r_cnt;

  logic w_tohost_sel;
  logic w_terminal;
  logic w_cnt_last;

  // Only full-word stores to the tohost word count; an even value is a
  // syscall request and never ends the test.
  assign w_tohost_sel = wr_en && (wr_strb == 4'hF) && (wr_addr == TOHOST_ADDR);
  assign w_terminal   = w_tohost_sel && wr_data[0];
  assign w_cnt_last   = (r_cnt == c_CNT_LAST);

  // The verdict is written only while done is clear, which makes the first
  // verdict final. The terminal store is tested before the timeout so a hit
  // on the last counted cycle still reports pass/fail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done     <= 1'b0;
      r_passed   <= 1'b0;
      r_timeout  <= 1'b0;
      r_test_num <= 31'd0;
      r_cnt      <= '0;
    end else if (!r_done) begin
      if (w_terminal) begin
        r_done     <= 1'b1;
        r_passed   <= (wr_data == 32'h0000_0001);
        r_test_num <= wr_data[31:1];
      end else if (w_cnt_last) begin
        r_done     <= 1'b1;
        r_timeout  <= 1'b1;
      end
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign done     = r_done;
  assign passed   = r_passed;
  assign timeout  = r_timeout;
  assign test_num = r_test_num;

  report_byte_tx u_tx (
    .clk      (clk),
    .rst      (rst),
    .done     (r_done),
    .passed   (r_passed),
    .timeout  (r_timeout),
    .test_num (r_test_num),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

endmodule : tohost_reporter

`default_nettype wire

// File: tb/tb_tohost_reporter.sv
//------------------------------------------------------------------------------
// Module   : tb_tohost_reporter
// Purpose  : Scoreboard bench for tohost_reporter. A reference model derives
//            the verdict and the expected ASCII line from the store stream and
//            the cycle count since reset release; a monitor compares every
//            transmitted byte and the status flags each cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_tohost_reporter;

  localparam logic [31:0] c_TA = 32'h0000_1000;
  localparam int          c_TO = 20;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        wr_en    = 1'b0;
  logic [31:0] wr_addr  = 32'h0;
  logic [31:0] wr_data  = 32'h0;
  logic [3:0]  wr_strb  = 4'h0;
  logic        tx_ready = 1'b0;
  logic        done;
  logic        passed;
  logic        timeout;
  logic [30:0] test_num;
  logic        tx_valid;
  logic [7:0]  tx_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          edge_cnt   = 0;
  bit          m_done     = 1'b0;
  bit          m_pass     = 1'b0;
  bit          m_to       = 1'b0;
  logic [30:0] m_tnum     = 31'd0;
  logic [7:0]  exp_q[$];

  // Monitor state
  bit         held       = 1'b0;
  logic [7:0] held_byte  = 8'h00;
  int         bytes_seen = 0;
  bit         rdy_random = 1'b0;

  tohost_reporter #(
    .TOHOST_ADDR    (c_TA),
    .TIMEOUT_CYCLES (c_TO),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .done     (done),
    .passed   (passed),
    .timeout  (timeout),
    .test_num (test_num),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  // Expected verdict line built from text templates.
  function automatic void push_msg();
    string       hx;
    logic [31:0] word;
    hx = "0123456789ABCDEF";
    if (m_to) begin
      push_str("timeout\n");
    end else if (m_pass) begin
      push_str("passed\n");
    end else begin
      push_str("failed ");
      word = {1'b0, m_tnum};
      for (int d = 7; d >= 0; d--) begin
        exp_q.push_back(hx[(word >> (4 * d)) & 32'hF]);
      end
      push_str("\n");
    end
  endfunction

  function automatic void clear_model();
    edge_cnt   = 0;
    m_done     = 1'b0;
    m_pass     = 1'b0;
    m_to       = 1'b0;
    m_tnum     = 31'd0;
    exp_q.delete();
    held       = 1'b0;
    bytes_seen = 0;
  endfunction

  // Reference model: edges are numbered from 1 after reset release; the first
  // odd full-word store to tohost at or before edge c_TO decides, otherwise
  // edge c_TO declares a timeout.
  always @(posedge clk) begin
    if (rst) begin
      edge_cnt++;
      if (!m_done) begin
        if (wr_en && wr_strb == 4'hF && wr_addr == c_TA && wr_data[0]) begin
          m_done = 1'b1;
          m_pass = (wr_data == 32'h1);
          m_tnum = m_pass ? 31'd0 : wr_data[31:1];
          push_msg();
        end else if (edge_cnt == c_TO) begin
          m_done = 1'b1;
          m_to   = 1'b1;
          push_msg();
        end
      end
    end
  end

  // Monitor: sampled on the falling edge; tx_ready is already set for the
  // coming rising edge, so valid & ready here is a handshake at that edge.
  always @(negedge clk) begin
    logic [7:0] b;
    check("flags", {29'd0, done, passed, timeout, test_num}, {29'd0, m_done, m_pass, m_to, m_tnum});
    if (tx_valid) begin
      if (held) check("hold_data", {56'd0, tx_data}, {56'd0, held_byte});
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          fail_event("extra_byte", $sformatf("got 0x%0h, expected no byte", tx_data));
        end else begin
          b = exp_q.pop_front();
          check("tx_byte", {56'd0, tx_data}, {56'd0, b});
          bytes_seen++;
        end
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_byte = tx_data;
      end
    end else begin
      if (held) fail_event("valid_dropped", "got tx_valid=0, expected 1 while stalled");
      held = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic cyc(input logic en, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk);
    #1;
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
    wr_strb = s;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (!(m_done && exp_q.size() == 0 && !tx_valid && !held) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) fail_event("drain", $sformatf("message incomplete, %0d bytes outstanding", exp_q.size()));
    else n_cmp++;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          k;

    // Reset state
    #2;
    check("reset_outputs", {23'd0, done, passed, timeout, test_num, tx_valid, tx_data},
          64'd0);

    // 1: pass with the sink always ready
    rdy_random = 1'b0;
    do_reset();
    idle(2);
    cyc(1'b1, c_TA, 32'h1, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(100);

    // 2: fail, test 3
    do_reset();
    idle(1);
    cyc(1'b1, c_TA, 32'h0000_0007, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(100);

    // 3: timeout with no store
    do_reset();
    drain(100);

    // 4: filtered stores, then pass
    do_reset();
    cyc(1'b1, c_TA, 32'h1, 4'h1);
    cyc(1'b1, c_TA + 32'd4, 32'h1, 4'hF);
    cyc(1'b1, c_TA, 32'h2, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    check("filter_done", {63'd0, done}, 64'd0);
    cyc(1'b1, c_TA, 32'h1, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(100);

    // 5: fail 0xFFF under random backpressure
    rdy_random = 1'b1;
    do_reset();
    cyc(1'b1, c_TA, 32'h0000_0FFF, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(300);

    // 6: pass, a later store of 5 is ignored, reset after the third byte
    rdy_random = 1'b0;
    do_reset();
    cyc(1'b1, c_TA, 32'h1, 4'hF);
    cyc(1'b1, c_TA, 32'h5, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    k = 0;
    while (bytes_seen < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_event("third_byte", "third byte never transferred");
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_model();
    #1;
    check("rst_async_out", {23'd0, done, passed, timeout, test_num, tx_valid, tx_data}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(8);
    cyc(1'b1, c_TA, 32'h1, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(100);

    // Boundary: terminal store sampled on the last counted edge beats timeout,
    // one edge later the timeout has already won.
    do_reset();
    idle(18);
    cyc(1'b1, c_TA, 32'h0000_0009, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(100);
    do_reset();
    idle(19);
    cyc(1'b1, c_TA, 32'h0000_0009, 4'hF);
    cyc(1'b0, 32'h0, 32'h0, 4'h0);
    drain(100);

    // Randomized scenarios
    for (int sc = 0; sc < 30; sc++) begin
      rdy_random = 1'($urandom_range(0, 1));
      do_reset();
      for (int c = 0; c < 24; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0, 1:    a = c_TA;
            2:       a = c_TA + 32'd4;
            default: a = $urandom & 32'hFFFF_FFFC;
          endcase
          s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          case ($urandom_range(0, 3))
            0:       d = 32'h1;
            1:       d = $urandom | 32'h1;
            2:       d = $urandom & 32'hFFFF_FFFE;
            default: d = 32'h5;
          endcase
          cyc(1'b1, a, d, s);
        end else begin
          cyc(1'b0, 32'h0, 32'h0, 4'h0);
        end
      end
      cyc(1'b0, 32'h0, 32'h0, 4'h0);
      drain(300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tohost_reporter

`default_nettype wire
